// File: rtl/reg_to_obi_bridge.sv
// ============================================================================
// Module   : reg_to_obi_bridge
// Purpose  : Register-bus responder that replays each reg access as a single
//            OBI initiator transaction. One transaction outstanding; the
//            request is latched on acceptance and the response is registered.
// Revision : 1.0 - initial release
//
// Optional feature macro : REG_TO_OBI_TIMEOUT_EN
//   Defined   -> WAIT is bounded by TIMEOUT_CYCLES; on expiry an error
//                response carrying ERR_RDATA is returned and the late rvalid
//                is later drained in DRAIN.
//   Undefined -> no counter and no DRAIN state; reg_error_o is always 0.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   reg_valid_i          reg request valid (held until reg_ready_o)
//   reg_write_i          1 = write, 0 = read
//   reg_addr_i [31:0]    byte address
//   reg_wdata_i[31:0]    write data
//   reg_wstrb_i[3:0]     write byte strobes
//   reg_ready_o          one-cycle response pulse
//   reg_rdata_o[31:0]    read data, valid with reg_ready_o
//   reg_error_o          error flag, valid with reg_ready_o
//   obi_req_o/obi_gnt_i  OBI address-phase handshake
//   obi_addr_o[31:0]     word-aligned OBI address
//   obi_we_o, obi_be_o   OBI write enable / byte enables
//   obi_wdata_o[31:0]    OBI write data
//   obi_rvalid_i         OBI response valid
//   obi_rdata_i[31:0]    OBI response data
// ============================================================================
`default_nettype none

module reg_to_obi_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hBADCAB1E
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        reg_valid_i,
    input  logic        reg_write_i,
    input  logic [31:0] reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    input  logic [3:0]  reg_wstrb_i,
    output logic        reg_ready_o,
    output logic [31:0] reg_rdata_o,
    output logic        reg_error_o,
    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i
);

`ifdef REG_TO_OBI_TIMEOUT_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;     // request latched this cycle
    logic        w_rsp_ok;     // normal OBI response captured this cycle
    logic        w_timeout;    // WAIT expired this cycle

    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_error;
    logic        w_unused;

`ifdef REG_TO_OBI_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_drain_pend;  // a timed-out rvalid is still owed by the slave

    assign w_unused = ^reg_addr_i[1:0];
`else
    assign w_unused = ^{reg_addr_i[1:0], ERR_RDATA, 32'(TIMEOUT_CYCLES)};
`endif

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rsp_ok    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (reg_valid_i) begin
                    w_accept = 1'b1;
                    // Write with no strobes has nothing to do on OBI.
                    if (reg_write_i && (reg_wstrb_i == 4'h0)) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (obi_gnt_i) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                // rvalid in the grant cycle is seen in REQ and thus ignored.
                if (obi_rvalid_i) begin
                    w_rsp_ok    = 1'b1;
                    w_state_nxt = RESP;
                end
`ifdef REG_TO_OBI_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
`endif
            end
            RESP: begin
                w_state_nxt = IDLE;
`ifdef REG_TO_OBI_TIMEOUT_EN
                // A late rvalid landing in RESP already settles the debt.
                if (r_drain_pend && !obi_rvalid_i) begin
                    w_state_nxt = DRAIN;
                end
`endif
            end
`ifdef REG_TO_OBI_TIMEOUT_EN
            DRAIN: begin
                if (obi_rvalid_i) begin
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_addr  <= 32'h0;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= {reg_addr_i[31:2], 2'b00};
                r_we    <= reg_write_i;
                r_be    <= reg_write_i ? reg_wstrb_i : 4'hF;
                r_wdata <= reg_wdata_i;
                r_rdata <= 32'h0;
                r_error <= 1'b0;
            end
            if (w_rsp_ok) begin
                r_rdata <= obi_rdata_i;
                r_error <= 1'b0;
            end
            if (w_timeout) begin
                r_rdata <= ERR_RDATA;
                r_error <= 1'b1;
            end
        end
    end

`ifdef REG_TO_OBI_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt        <= '0;
            r_drain_pend <= 1'b0;
        end else begin
            if (r_state == REQ) begin
                r_cnt <= '0;
            end else if (r_state == WAIT && !obi_rvalid_i) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_drain_pend <= 1'b1;
            end else if (r_state == RESP) begin
                r_drain_pend <= 1'b0;
            end
        end
    end
`endif

    assign obi_req_o   = (r_state == REQ);
    assign reg_ready_o = (r_state == RESP);
    assign reg_rdata_o = r_rdata;
    assign reg_error_o = r_error;
    assign obi_addr_o  = r_addr;
    assign obi_we_o    = r_we;
    assign obi_be_o    = r_be;
    assign obi_wdata_o = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_reg_to_obi_bridge.sv
// ============================================================================
// Module   : tb_reg_to_obi_bridge
// Purpose  : Directed self-checking bench for reg_to_obi_bridge. The bench
//            plays both the reg-bus master and the OBI slave, cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_to_obi_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        reg_valid_i;
    logic        reg_write_i;
    logic [31:0] reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [3:0]  reg_wstrb_i;
    logic        reg_ready_o;
    logic [31:0] reg_rdata_o;
    logic        reg_error_o;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;

    int n_vec = 0;
    int n_err = 0;

    reg_to_obi_bridge #(
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hBADCAB1E)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .reg_valid_i  (reg_valid_i),
        .reg_write_i  (reg_write_i),
        .reg_addr_i   (reg_addr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_wstrb_i  (reg_wstrb_i),
        .reg_ready_o  (reg_ready_o),
        .reg_rdata_o  (reg_rdata_o),
        .reg_error_o  (reg_error_o),
        .obi_req_o    (obi_req_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".req"},   32'(obi_req_o),   32'h0);
        check({tag, ".ready"}, 32'(reg_ready_o), 32'h0);
        check({tag, ".error"}, 32'(reg_error_o), 32'h0);
        check({tag, ".rdata"}, reg_rdata_o,      32'h0);
        check({tag, ".addr"},  obi_addr_o,       32'h0);
        check({tag, ".we"},    32'(obi_we_o),    32'h0);
        check({tag, ".be"},    32'(obi_be_o),    32'h0);
        check({tag, ".wdata"}, obi_wdata_o,      32'h0);
    endtask

    initial begin
        rst_i        = 1'b1;
        reg_valid_i  = 1'b0;
        reg_write_i  = 1'b0;
        reg_addr_i   = 32'h0;
        reg_wdata_i  = 32'h0;
        reg_wstrb_i  = 4'h0;
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = 32'h0;
        tick();
        tick();
        rst_i = 1'b0;
        check_all_zero("reset");

        // ---- Read 0x2000_0006, grant in first REQ cycle, rvalid next ----
        reg_valid_i = 1'b1;
        reg_write_i = 1'b0;
        reg_addr_i  = 32'h2000_0006;
        reg_wdata_i = 32'hFFFF_FFFF;
        reg_wstrb_i = 4'h0;
        tick();                                   // c1: REQ
        check("rd.req_c1",  32'(obi_req_o), 32'h1);
        check("rd.addr",    obi_addr_o,     32'h2000_0004);
        check("rd.be",      32'(obi_be_o),  32'hF);
        check("rd.we",      32'(obi_we_o),  32'h0);
        check("rd.ready_c1", 32'(reg_ready_o), 32'h0);
        obi_gnt_i = 1'b1;
        tick();                                   // c2: WAIT
        obi_gnt_i = 1'b0;
        check("rd.req_c2",   32'(obi_req_o),   32'h0);
        check("rd.ready_c2", 32'(reg_ready_o), 32'h0);
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'hCAFE_F00D;
        tick();                                   // c3: RESP
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = 32'h0;
        check("rd.ready_c3", 32'(reg_ready_o), 32'h1);
        check("rd.rdata",    reg_rdata_o,      32'hCAFE_F00D);
        check("rd.error",    32'(reg_error_o), 32'h0);
        reg_valid_i = 1'b0;
        tick();
        check("rd.ready_c4", 32'(reg_ready_o), 32'h0);

        // ---- Write 0x10, grant delayed 5 cycles (req held 6 cycles) ----
        reg_valid_i = 1'b1;
        reg_write_i = 1'b1;
        reg_addr_i  = 32'h0000_0010;
        reg_wdata_i = 32'h1234_5678;
        reg_wstrb_i = 4'b0110;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("wr.req",   32'(obi_req_o),   32'h1);
            check("wr.addr",  obi_addr_o,       32'h0000_0010);
            check("wr.be",    32'(obi_be_o),    32'h6);
            check("wr.we",    32'(obi_we_o),    32'h1);
            check("wr.wdata", obi_wdata_o,      32'h1234_5678);
            check("wr.ready", 32'(reg_ready_o), 32'h0);
            if (k == 2) begin
                // Master changes its lines while the bridge is busy.
                reg_addr_i  = 32'hFFFF_0000;
                reg_wdata_i = 32'h0;
                reg_wstrb_i = 4'hF;
            end
            if (k == 6) begin
                obi_gnt_i    = 1'b1;
                obi_rvalid_i = 1'b1;              // same-cycle rvalid must be ignored
                obi_rdata_i  = 32'hDEAD_BEEF;
            end
        end
        tick();                                   // c7: WAIT
        obi_gnt_i    = 1'b0;
        check("wr.req_wait",   32'(obi_req_o),   32'h0);
        check("wr.ready_wait", 32'(reg_ready_o), 32'h0);
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h0BAD_F00D;
        tick();                                   // c8: RESP
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = 32'h0;
        check("wr.ready_resp", 32'(reg_ready_o), 32'h1);
        check("wr.error",      32'(reg_error_o), 32'h0);
        check("wr.rdata",      reg_rdata_o,      32'h0BAD_F00D);
        reg_valid_i = 1'b0;
        tick();
        check("wr.ready_after", 32'(reg_ready_o), 32'h0);

        // ---- Write with wstrb = 0: no OBI transaction ----
        reg_valid_i = 1'b1;
        reg_write_i = 1'b1;
        reg_addr_i  = 32'h0000_0040;
        reg_wdata_i = 32'h5555_AAAA;
        reg_wstrb_i = 4'h0;
        tick();
        check("z.ready", 32'(reg_ready_o), 32'h1);
        check("z.req",   32'(obi_req_o),   32'h0);
        check("z.error", 32'(reg_error_o), 32'h0);
        check("z.rdata", reg_rdata_o,      32'h0);
        reg_valid_i = 1'b0;
        tick();
        check("z.ready_after", 32'(reg_ready_o), 32'h0);
        check("z.req_after",   32'(obi_req_o),   32'h0);

`ifdef REG_TO_OBI_TIMEOUT_EN
        // ---- Timeout: grant immediately, rvalid withheld ~20 cycles ----
        reg_valid_i = 1'b1;
        reg_write_i = 1'b0;
        reg_addr_i  = 32'h0000_0100;
        tick();                                   // c1: REQ
        check("to.req", 32'(obi_req_o), 32'h1);
        obi_gnt_i = 1'b1;
        tick();                                   // c2: first WAIT cycle
        obi_gnt_i = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            check("to.ready_wait", 32'(reg_ready_o), 32'h0);
            tick();
        end
        check("to.ready", 32'(reg_ready_o), 32'h1);     // c10
        check("to.error", 32'(reg_error_o), 32'h1);
        check("to.rdata", reg_rdata_o,      32'hBADC_AB1E);
        reg_valid_i = 1'b0;
        tick();                                   // c11: DRAIN
        check("to.ready_after", 32'(reg_ready_o), 32'h0);
        reg_valid_i = 1'b1;
        reg_addr_i  = 32'h0000_0200;
        repeat (11) begin
            tick();
            check("to.drain_req",   32'(obi_req_o),   32'h0);
            check("to.drain_ready", 32'(reg_ready_o), 32'h0);
        end
        obi_rvalid_i = 1'b1;                      // c22: late rvalid
        obi_rdata_i  = 32'h1111_1111;
        tick();                                   // c23: IDLE
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = 32'h0;
        check("to.idle_req", 32'(obi_req_o), 32'h0);
        tick();                                   // c24: REQ
        check("to.next_req",  32'(obi_req_o), 32'h1);
        check("to.next_addr", obi_addr_o,     32'h0000_0200);
        obi_gnt_i = 1'b1;
        tick();
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h600D_D00D;
        tick();
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = 32'h0;
        check("to.next_ready", 32'(reg_ready_o), 32'h1);
        check("to.next_error", 32'(reg_error_o), 32'h0);
        check("to.next_rdata", reg_rdata_o,      32'h600D_D00D);
        reg_valid_i = 1'b0;
        tick();
`endif

        // ---- Reset while in WAIT, then stale rvalid ----
        reg_valid_i = 1'b1;
        reg_write_i = 1'b0;
        reg_addr_i  = 32'h0000_0300;
        tick();                                   // REQ
        obi_gnt_i = 1'b1;
        tick();                                   // WAIT
        obi_gnt_i   = 1'b0;
        rst_i       = 1'b1;
        reg_valid_i = 1'b0;
        tick();
        rst_i = 1'b0;
        check_all_zero("rst");
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h57A1_E000;
        tick();
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = 32'h0;
        check("rst.stale_ready", 32'(reg_ready_o), 32'h0);
        check("rst.stale_req",   32'(obi_req_o),   32'h0);
        tick();
        check("rst.stale_ready2", 32'(reg_ready_o), 32'h0);
        reg_valid_i = 1'b1;
        reg_addr_i  = 32'h0000_0304;
        tick();
        check("rst.next_req",  32'(obi_req_o), 32'h1);
        check("rst.next_addr", obi_addr_o,     32'h0000_0304);
        obi_gnt_i = 1'b1;
        tick();
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'h7777_0304;
        tick();
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = 32'h0;
        check("rst.next_ready", 32'(reg_ready_o), 32'h1);
        check("rst.next_rdata", reg_rdata_o,      32'h7777_0304);
        reg_valid_i = 1'b0;
        tick();

        // ---- Back-to-back reads against a zero-wait slave ----
        obi_gnt_i    = 1'b1;
        obi_rvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            reg_valid_i = 1'b1;
            reg_write_i = 1'b0;
            reg_addr_i  = 32'h0000_0400 + 32'(4 * i);
            obi_rdata_i = 32'hA000_0000 + 32'(i);
            tick();
            check("b2b.req",    32'(obi_req_o),   32'h1);
            check("b2b.addr",   obi_addr_o,       32'h0000_0400 + 32'(4 * i));
            check("b2b.ready1", 32'(reg_ready_o), 32'h0);
            tick();
            check("b2b.ready2", 32'(reg_ready_o), 32'h0);
            tick();
            check("b2b.ready3", 32'(reg_ready_o), 32'h1);
            check("b2b.rdata",  reg_rdata_o,      32'hA000_0000 + 32'(i));
            reg_valid_i = 1'b0;
            tick();
            check("b2b.ready4", 32'(reg_ready_o), 32'h0);
        end
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
